// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//   PS/2 device-to-host frame receiver.
//   Datapath: 2-FF synchronisers -> ps2_clk glitch filter -> frame FSM -> byte FIFO.
//   The FSM walks IDLE -> SHIFT -> CHECK. CHECK verifies odd parity and the stop bit,
//   then either pushes the byte into the FIFO or raises an error/overflow pulse.
//   The FIFO is first-word fall-through: rd_data already shows the head entry.
//
//   Optional feature macro: PS2_RX_TIMEOUT_EN
//     defined   : inactivity watchdog. A frame is aborted with frame_err when no
//                 falling edge arrives within TIMEOUT_CYC clk cycles while in SHIFT.
//     undefined : no watchdog. SHIFT waits indefinitely and TIMEOUT_CYC is ignored.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       enable_rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
`ifdef PS2_RX_TIMEOUT_EN
    localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // A received byte plus its parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // ------------------------------------------------------------------
    // Synchronisers and clock-line glitch filter
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync_r;
    logic [1:0]            data_sync_r;
    logic [FILTER_LEN-1:0] filt_sr_r;
    logic                  filt_level_r;
    logic                  fall_edge_s;
    logic                  data_s;

    // Two-stage synchronisers for both raw PS/2 lines; idle lines are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Filter: the level only changes after FILTER_LEN identical synced samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_sr_r    <= '1;
            filt_level_r <= 1'b1;
        end else begin
            filt_sr_r <= {filt_sr_r[FILTER_LEN-2:0], clk_sync_r[1]};
            if (filt_sr_r == '1) begin
                filt_level_r <= 1'b1;
            end else if (filt_sr_r == '0) begin
                filt_level_r <= 1'b0;
            end else begin
                filt_level_r <= filt_level_r;
            end
        end
    end

    // A falling edge is the single cycle in which the filtered level is about to drop.
    always_comb begin
        fall_edge_s = filt_level_r & (filt_sr_r == '0);
        data_s      = data_sync_r[1];
    end

    // ------------------------------------------------------------------
    // FIFO status and push/pop decisions
    // ------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             pop_s;
    logic             push_s;
    logic             frame_ok_s;

    state_t           state_r;
    logic [9:0]       shift_r;
    logic [3:0]       bit_cnt_r;
    logic             frame_done_r;
    logic             frame_err_r;
    logic             overflow_r;
`ifdef PS2_RX_TIMEOUT_EN
    logic [WD_W-1:0]  wd_cnt_r;
`endif

    // Frame verdict and FIFO handshake. A pop in the CHECK cycle frees the slot
    // the new byte needs, so a full FIFO can still accept that frame.
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                       (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]);
        pop_s        = rd_en & ~fifo_empty_s;
        frame_ok_s   = odd_parity_ok(shift_r[8:0]) & shift_r[9];
        if (state_r == ST_CHECK) begin
            push_s = frame_ok_s & (~fifo_full_s | pop_s);
        end else begin
            push_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered status pulses
    // ------------------------------------------------------------------
    // Collects start/data/parity/stop bits, judges the frame and raises result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= 10'd0;
            bit_cnt_r    <= 4'd0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            wd_cnt_r     <= '0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Only a low start bit opens a frame; a high one is ignored.
                    if (fall_edge_s && enable_rx && !data_s) begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= 4'd0;
`ifdef PS2_RX_TIMEOUT_EN
                        wd_cnt_r  <= '0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (fall_edge_s) begin
                        // LSB-first: after ten shifts bit 0 holds data[0], bit 9 the stop bit.
                        shift_r   <= {data_s, shift_r[9:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
`ifdef PS2_RX_TIMEOUT_EN
                        wd_cnt_r  <= '0;
`endif
                        if (bit_cnt_r == 4'd9) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
`ifdef PS2_RX_TIMEOUT_EN
                    end else if (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1)) begin
                        // The device stalled mid-frame: drop the partial frame.
                        frame_err_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        wd_cnt_r    <= '0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                        state_r  <= ST_SHIFT;
                    end
`else
                    end else begin
                        state_r <= ST_SHIFT;
                    end
`endif
                end
                ST_CHECK: begin
                    if (push_s) begin
                        frame_done_r <= 1'b1;
                    end else if (frame_ok_s) begin
                        overflow_r <= 1'b1;
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Received-byte FIFO
    // ------------------------------------------------------------------
    // Storage and pointers; push and pop may happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[IDX_W-1:0]] <= shift_r[7:0];
                wr_ptr_r                   <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Output drive: every value below comes straight from a register or a register decode.
    always_comb begin
        rd_data    = mem_r[rd_ptr_r[IDX_W-1:0]];
        rd_valid   = ~fifo_empty_s;
        frame_done = frame_done_r;
        frame_err  = frame_err_r;
        overflow   = overflow_r;
        busy       = (state_r != ST_IDLE);
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Testbench for ps2_rx_frame: directed scenarios plus randomized frames,
// checked against a queue-based reference model of the received byte stream.
module tb_ps2_rx_frame;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       enable_rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int obs_done = 0, obs_err = 0, obs_ovf = 0;
    int exp_done = 0, exp_err = 0, exp_ovf = 0;
    byte unsigned model_q[$];

    ps2_rx_frame #(.FILTER_LEN(8), .TIMEOUT_CYC(5000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .enable_rx(enable_rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: counts result pulses and checks they never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) obs_done++;
            if (frame_err)  obs_err++;
            if (overflow)   obs_ovf++;
            if (frame_done || frame_err || overflow)
                check_eq("pulse_excl", int'(frame_done) + int'(frame_err) + int'(overflow), 1);
        end
    end

    // Reference model: a complete frame is judged purely from the bits on the wire.
    function automatic void model_frame(input logic [7:0] d, input logic p, input logic s);
        if (((^{p, d}) == 1'b1) && (s == 1'b1)) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(d);
                exp_done++;
            end else begin
                exp_ovf++;
            end
        end else begin
            exp_err++;
        end
    endfunction

    task automatic check_counts(input string tag);
        check_eq({tag, "_done"}, obs_done, exp_done);
        check_eq({tag, "_err"},  obs_err,  exp_err);
        check_eq({tag, "_ovf"},  obs_ovf,  exp_ovf);
    endtask

    task automatic read_one();
        check_eq("rd_valid", rd_valid, (model_q.size() != 0) ? 1 : 0);
        if (model_q.size() != 0) begin
            check_eq("rd_data", rd_data, model_q[0]);
            rd_en = 1'b1;
            idle_cycles(1);
            rd_en = 1'b0;
            void'(model_q.pop_front());
        end
    endtask

    task automatic drain();
        while (model_q.size() != 0) read_one();
        check_eq("drained_valid", rd_valid, 0);
    endtask

    // Drives one PS/2 frame (or its first nbits bits), 40-clk half periods.
    // glitch_after: bit index after which a 5-clk low glitch is inserted (-1: none).
    // en_drop_after: bit index after which enable_rx is dropped (-1: never).
    // modelled: whether the receiver is expected to see this frame at all.
    task automatic send_frame(input logic [7:0] d, input bit par_bad, input logic stop_bit,
                              input int nbits, input int glitch_after, input int en_drop_after,
                              input bit pop_at_check, input bit chk_latency, input bit modelled);
        logic [10:0] bits;
        bit          ok;
        bit          was_full;
        logic        par;
        par      = (~^d) ^ par_bad;
        bits     = {stop_bit, par, d, 1'b0};
        ok       = ((^{par, d}) == 1'b1) && (stop_bit == 1'b1);
        was_full = (model_q.size() >= DEPTH);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            idle_cycles(20);
            ps2_clk = 1'b0;
            if (i == 10 && (pop_at_check || chk_latency)) begin
                idle_cycles(11);
                if (chk_latency) begin
                    check_eq("lat_n1_busy",  busy, 1);
                    check_eq("lat_n1_valid", rd_valid, (model_q.size() != 0) ? 1 : 0);
                end
                if (pop_at_check) begin
                    check_eq("pop_valid", rd_valid, 1);
                    if (model_q.size() != 0) check_eq("pop_data", rd_data, model_q[0]);
                    rd_en = 1'b1;
                end
                idle_cycles(1);
                rd_en = 1'b0;
                if (pop_at_check && model_q.size() != 0) void'(model_q.pop_front());
                if (chk_latency) begin
                    check_eq("lat_n2_busy",  busy, 0);
                    check_eq("lat_n2_done",  frame_done, (ok && !was_full) ? 1 : 0);
                    check_eq("lat_n2_err",   frame_err, ok ? 0 : 1);
                    check_eq("lat_n2_valid", rd_valid, ((model_q.size() != 0) || ok) ? 1 : 0);
                end
                idle_cycles(28);
            end else begin
                idle_cycles(40);
            end
            ps2_clk = 1'b1;
            idle_cycles(20);
            if (i == glitch_after) begin
                ps2_clk = 1'b0;
                idle_cycles(5);
                ps2_clk = 1'b1;
                idle_cycles(20);
            end
            if (i == en_drop_after) enable_rx = 1'b0;
        end
        ps2_data = 1'b1;
        if (nbits == 11 && modelled) model_frame(d, par, stop_bit);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, rd_valid, 0);
        check_eq({tag, "_data"},  rd_data, 0);
        check_eq({tag, "_done"},  frame_done, 0);
        check_eq({tag, "_err"},   frame_err, 0);
        check_eq({tag, "_ovf"},   overflow, 0);
        check_eq({tag, "_busy"},  busy, 0);
    endtask

    int base_err;
    int waited;
    int nr;

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; enable_rx = 1'b1; rd_en = 1'b0;
        idle_cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_cycles(20);

        // 1: good 0x1C with exact latency
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b1, 1'b1);
        idle_cycles(10);
        check_counts("t1");
        read_one();

        // 2: bad parity
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1, -1, 1'b0, 1'b1, 1'b1);
        check_counts("t2");
        check_eq("t2_valid", rd_valid, 0);

        // rd_en while empty has no effect
        rd_en = 1'b1; idle_cycles(1); rd_en = 1'b0;
        check_eq("empty_rd_valid", rd_valid, 0);

        // 3: five frames, no reads -> overflow on fifth
        for (int v = 1; v <= 5; v++)
            send_frame(8'(v), 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b1);
        check_counts("t3");
        drain();

        // 4: full FIFO, pop in the CHECK cycle of 0x5A
        for (int v = 1; v <= 4; v++)
            send_frame(8'(v + 16), 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 11, -1, -1, 1'b1, 1'b0, 1'b1);
        check_counts("t4");
        drain();

        // enable_rx low for a whole frame: ignored
        enable_rx = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b0);
        check_counts("en_off");
        check_eq("en_off_busy", busy, 0);
        enable_rx = 1'b1;
        // enable_rx dropped mid-frame: frame still completes
        send_frame(8'hA7, 1'b0, 1'b1, 11, -1, 2, 1'b0, 1'b0, 1'b1);
        enable_rx = 1'b1;
        check_counts("en_mid");
        drain();

        // 5: clock stops after start + 4 bits
        send_frame(8'h96, 1'b0, 1'b1, 5, -1, -1, 1'b0, 1'b0, 1'b0);
`ifdef PS2_RX_TIMEOUT_EN
        base_err = obs_err;
        waited = 0;
        while (obs_err == base_err && waited < 6000) begin
            idle_cycles(1);
            waited++;
        end
        exp_err++;
        check_eq("wd_window", ((waited + 60) >= 5000 && (waited + 60) <= 5025) ? 1 : 0, 1);
        check_counts("t5");
        check_eq("t5_busy", busy, 0);
`else
        idle_cycles(6000);
        check_counts("t5");
        check_eq("t5_busy", busy, 1);
        rst = 1'b1; idle_cycles(2); rst = 1'b0; idle_cycles(5);
        model_q.delete();
`endif
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b1);
        check_counts("t5b");
        drain();

        // 6: 5-clk glitch mid-frame, then reset mid-frame
        send_frame(8'h3C, 1'b0, 1'b1, 11, 3, -1, 1'b0, 1'b0, 1'b1);
        check_counts("t6g");
        send_frame(8'h11, 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 5, -1, -1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_cycles(2);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        model_q.delete();
        idle_cycles(5);
        check_eq("rst_mid_valid_after", rd_valid, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 11, -1, -1, 1'b0, 1'b0, 1'b1);
        check_counts("t6r");
        drain();

        // Randomized frames with random reads
        for (int n = 0; n < 25; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) != 0),
                       11, -1, -1, 1'b0, 1'b0, 1'b1);
            check_counts("rnd");
            nr = $urandom_range(0, 2);
            for (int r = 0; r < nr; r++) read_one();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
